// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the RV64 five-stage core: load-use interlock, MDU occupancy, branch redirect, debug halt.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned XLEN              = 64,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            ex_mdu_start,
  input  logic            mdu_done,
  input  logic            halt_req,
  output logic            pc_stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_stall,
  output logic            id_ex_flush,
  output logic            halted
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flush_count,
  output logic [CNT_W-1:0] perf_mdu_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MDU_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       hz;
  logic       if_id_flush_raw;

  assign hz = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    pc_stall        = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = '0;
    if_id_stall     = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_flush     = 1'b0;
    halted          = 1'b0;
    // Outputs are held at zero for the whole reset cycle regardless of state.
    if (!rst) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            branch_taken    = 1'b1;
            branch_target   = ex_branch_target;
            if_id_flush_raw = 1'b1;
            id_ex_flush     = 1'b1;
          end else if (ex_mdu_start) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            state_nxt   = MDU_WAIT;
          end else if (hz) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_nxt   = LD_RELOAD;
              state_nxt = LD_STALL;
            end
          end else if (halt_req) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            state_nxt   = HALT;
          end
        end
        LD_STALL: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          cnt_nxt     = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = RUN;
        end
        MDU_WAIT: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          if (mdu_done) state_nxt = RUN;
        end
        HALT: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          halted      = halt_req;
          if (!halt_req) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // A stall on IF/ID always wins over a flush of the same register.
  assign if_id_flush = if_id_flush_raw && !if_id_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
      perf_mdu_cycles   <= '0;
    end else begin
      if (pc_stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (branch_taken && (perf_flush_count != '1))
        perf_flush_count <= perf_flush_count + 1'b1;
      if ((state == MDU_WAIT) && (perf_mdu_cycles != '1))
        perf_mdu_cycles <= perf_mdu_cycles + 1'b1;
    end
  end
`else
  logic perf_unused;
  assign perf_unused = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (1 and 3 load-stall cycles) against a reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        mem_read;
    logic        br;
    logic [63:0] tgt;
    logic        mdu_start;
    logic        mdu_done;
    logic        halt;
  } in_t;

  // flags: {pc_stall, branch_taken, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, halted}
  typedef struct packed {
    logic [6:0]  flags;
    logic [63:0] target;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_LD   = 7'b1010010;
  localparam logic [6:0] F_BR   = 7'b0101010;
  localparam logic [6:0] F_MDU  = 7'b1010100;
  localparam logic [6:0] F_HREQ = 7'b1010000;
  localparam logic [6:0] F_HLT  = 7'b1010001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic [63:0] ex_branch_target;
  logic        ex_mdu_start, mdu_done, halt_req;

  logic        a_pc_stall, a_br, a_ifs, a_iff, a_ies, a_ief, a_halted;
  logic [63:0] a_tgt;
  logic        b_pc_stall, b_br, b_ifs, b_iff, b_ies, b_ief, b_halted;
  logic [63:0] b_tgt;

  pipe_hazard_ctrl #(.XLEN(64), .LOAD_STALL_CYCLES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .halt_req(halt_req),
    .pc_stall(a_pc_stall), .branch_taken(a_br), .branch_target(a_tgt),
    .if_id_stall(a_ifs), .if_id_flush(a_iff), .id_ex_stall(a_ies),
    .id_ex_flush(a_ief), .halted(a_halted)
  );

  pipe_hazard_ctrl #(.XLEN(64), .LOAD_STALL_CYCLES(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .halt_req(halt_req),
    .pc_stall(b_pc_stall), .branch_taken(b_br), .branch_target(b_tgt),
    .if_id_stall(b_ifs), .if_id_flush(b_iff), .id_ex_stall(b_ies),
    .id_ex_flush(b_ief), .halted(b_halted)
  );

  // Minimal fetch PC driven by the 1-cycle instance, standing in for if_stage.
  logic [63:0] pc;
  always @(posedge clk) begin
    if (rst)            pc <= 64'd0;
    else if (a_br)      pc <= a_tgt;
    else if (!a_pc_stall) pc <= pc + 64'd4;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining-bubble count and busy/halt modes per instance.
  int unsigned ld_cycles [2] = '{1, 3};
  int          ld_left   [2] = '{0, 0};
  bit          mdu_busy  [2] = '{0, 0};
  bit          in_halt   [2] = '{0, 0};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int k, input in_t i, output out_t o);
    logic hz;
    o  = '0;
    hz = i.mem_read && (i.rd != 0) && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    if (i.rst) begin
      ld_left[k] = 0; mdu_busy[k] = 0; in_halt[k] = 0;
    end else if (mdu_busy[k]) begin
      o.flags = F_MDU;
      if (i.mdu_done) mdu_busy[k] = 0;
    end else if (ld_left[k] > 0) begin
      o.flags = F_LD;
      ld_left[k] = ld_left[k] - 1;
    end else if (in_halt[k]) begin
      o.flags = i.halt ? F_HLT : F_HREQ;
      if (!i.halt) in_halt[k] = 0;
    end else if (i.br) begin
      o.flags  = F_BR;
      o.target = i.tgt;
    end else if (i.mdu_start) begin
      o.flags = F_MDU;
      mdu_busy[k] = 1;
    end else if (hz) begin
      o.flags = F_LD;
      ld_left[k] = int'(ld_cycles[k]) - 1;
    end else if (i.halt) begin
      o.flags = F_HREQ;
      in_halt[k] = 1;
    end
  endtask

  // One clock cycle: drive, check both instances on the falling edge, advance.
  task automatic cyc(input in_t i, output out_t a1, output out_t a3);
    out_t e1, e3;
    rst = i.rst; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
    ex_rd = i.rd; ex_mem_read = i.mem_read; ex_branch_taken = i.br; ex_branch_target = i.tgt;
    ex_mdu_start = i.mdu_start; mdu_done = i.mdu_done; halt_req = i.halt;
    @(negedge clk);
    a1 = {{a_pc_stall, a_br, a_ifs, a_iff, a_ies, a_ief, a_halted}, a_tgt};
    a3 = {{b_pc_stall, b_br, b_ifs, b_iff, b_ies, b_ief, b_halted}, b_tgt};
    model(0, i, e1);
    model(1, i, e3);
    chk("model_ld1", a1, e1);
    chk("model_ld3", a3, e3);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic [4:0] rd, input logic mr, input logic br,
                             input logic [63:0] tgt, input logic ms, input logic md, input logic h);
    in_t r;
    r = '0;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd; r.mem_read = mr;
    r.br = br; r.tgt = tgt; r.mdu_start = ms; r.mdu_done = md; r.halt = h;
    return r;
  endfunction

  function automatic out_t ex(input logic [6:0] f, input logic [63:0] t);
    out_t r;
    r.flags  = f;
    r.target = t;
    return r;
  endfunction

  in_t  idle, rst_in, hz5, hz0, tmp;
  out_t o1, o3;
  vec_t vecs [20];
  logic [7:0]  pat1, pat3;
  logic [63:0] pc_h;
  logic        halt_lvl;

  initial begin
    idle   = '0;
    rst_in = '0;
    rst_in.rst = 1'b1;
    hz5 = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 64'd0, 0, 0, 0);
    hz0 = mk(5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 64'd0, 0, 0, 0);

    // Expected outputs are those of the 1-cycle instance.
    vecs[0]  = '{idle, ex(F_NONE, 0)};
    vecs[1]  = '{hz5, ex(F_LD, 0)};
    vecs[2]  = '{idle, ex(F_NONE, 0)};
    vecs[3]  = '{hz0, ex(F_NONE, 0)};
    vecs[4]  = '{mk(5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 64'd0, 0, 0, 0), ex(F_LD, 0)};
    vecs[5]  = '{mk(5'd9, 5'd0, 0, 0, 5'd9, 1, 0, 64'd0, 0, 0, 0), ex(F_NONE, 0)};
    vecs[6]  = '{mk(5'd9, 5'd0, 1, 0, 5'd9, 0, 0, 64'd0, 0, 0, 0), ex(F_NONE, 0)};
    vecs[7]  = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 64'h28, 0, 0, 0), ex(F_BR, 64'h28)};
    vecs[8]  = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'd0, 0, 0, 1), ex(F_HREQ, 0)};
    vecs[9]  = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'd0, 0, 0, 1), ex(F_HLT, 0)};
    vecs[10] = '{idle, ex(F_HREQ, 0)};
    vecs[11] = '{idle, ex(F_NONE, 0)};
    vecs[12] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'd0, 1, 0, 0), ex(F_MDU, 0)};
    vecs[13] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 64'h40, 0, 0, 1), ex(F_MDU, 0)};
    vecs[14] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'd0, 0, 1, 0), ex(F_MDU, 0)};
    vecs[15] = '{idle, ex(F_NONE, 0)};
    vecs[16] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 64'h10, 1, 0, 1), ex(F_BR, 64'h10)};
    vecs[17] = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 64'd0, 1, 0, 0), ex(F_MDU, 0)};
    vecs[18] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 64'd0, 0, 1, 0), ex(F_MDU, 0)};
    vecs[19] = '{idle, ex(F_NONE, 0)};

    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(rst_in, o1, o3);
    cyc(rst_in, o1, o3);
    chk("reset_out", o1, ex(F_NONE, 0));
    chk("reset_pc", {8'd0, pc}, 72'd0);

    for (int n = 0; n < 20; n++) begin
      cyc(vecs[n].in, o1, o3);
      chk($sformatf("vec%0d", n), o1, vecs[n].exp);
    end

    // Bubble count per load-use: 1 vs 3, and no stall for ex_rd == 0.
    for (int n = 0; n < 3; n++) cyc(idle, o1, o3);
    pat1 = '0; pat3 = '0;
    for (int n = 0; n < 6; n++) begin
      cyc((n == 0) ? hz5 : idle, o1, o3);
      pat1 = {pat1[6:0], o1.flags[6]};
      pat3 = {pat3[6:0], o3.flags[6]};
    end
    chk("ld1_pattern", {64'd0, pat1}, {64'd0, 8'b00100000});
    chk("ld3_pattern", {64'd0, pat3}, {64'd0, 8'b00111000});
    pat3 = '0;
    for (int n = 0; n < 4; n++) begin
      cyc((n == 0) ? hz0 : idle, o1, o3);
      pat3 = {pat3[6:0], o3.flags[6]};
    end
    chk("ld_rd0_pattern", {64'd0, pat3}, 72'd0);

    // PC behaviour: hold on load-use, redirect on branch+hazard.
    cyc(rst_in, o1, o3);
    cyc(idle, o1, o3);
    cyc(idle, o1, o3);
    chk("pc_before_hz", {8'd0, pc}, 72'h8);
    cyc(hz5, o1, o3);
    chk("pc_held_hz", {8'd0, pc}, 72'h8);
    cyc(idle, o1, o3);
    chk("pc_after_hz", {8'd0, pc}, 72'hC);
    tmp = hz5; tmp.br = 1'b1; tmp.tgt = 64'h28;
    cyc(tmp, o1, o3);
    chk("pc_branch", {8'd0, pc}, 72'h28);

    // MDU: start, branch during wait ignored, done on the 6th cycle after start.
    for (int n = 0; n < 3; n++) cyc(idle, o1, o3);
    pat1 = '0;
    for (int n = 0; n < 8; n++) begin
      tmp = idle;
      tmp.mdu_start = (n == 0);
      tmp.mdu_done  = (n == 6);
      tmp.br        = (n == 3);
      tmp.tgt       = 64'h100;
      cyc(tmp, o1, o3);
      pat1 = {pat1[6:0], o1.flags[2]};
    end
    chk("mdu_pattern", {64'd0, pat1}, {64'd0, 8'b11111110});

    // Halt for 4 cycles: PC frozen, then resumes from held value.
    pc_h = pc;
    tmp = idle; tmp.halt = 1'b1;
    for (int n = 0; n < 4; n++) cyc(tmp, o1, o3);
    chk("halt_halted", {71'd0, o1.flags[0]}, 72'd1);
    chk("halt_pc_held", {8'd0, pc}, {8'd0, pc_h});
    cyc(idle, o1, o3);
    chk("halt_exit_halted", {71'd0, o1.flags[0]}, 72'd0);
    cyc(idle, o1, o3);
    chk("halt_pc_resume", {8'd0, pc}, {8'd0, pc_h + 64'd4});

    // Reset in the middle of an MDU wait; a late done is inert.
    tmp = idle; tmp.mdu_start = 1'b1;
    cyc(tmp, o1, o3);
    cyc(idle, o1, o3);
    cyc(idle, o1, o3);
    cyc(rst_in, o1, o3);
    cyc(idle, o1, o3);
    chk("rst_mdu_out", o1, ex(F_NONE, 0));
    tmp = idle; tmp.mdu_done = 1'b1;
    cyc(tmp, o1, o3);
    chk("rst_mdu_done", o1, ex(F_NONE, 0));
    cyc(idle, o1, o3);

    // Randomized traffic, checked every cycle against the model.
    halt_lvl = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) halt_lvl = ~halt_lvl;
      tmp           = '0;
      tmp.rst       = ($urandom_range(0, 49) == 0);
      tmp.rs1       = 5'($urandom_range(0, 3));
      tmp.rs2       = 5'($urandom_range(0, 3));
      tmp.u1        = 1'($urandom_range(0, 1));
      tmp.u2        = 1'($urandom_range(0, 1));
      tmp.rd        = 5'($urandom_range(0, 3));
      tmp.mem_read  = 1'($urandom_range(0, 1));
      tmp.br        = ($urandom_range(0, 6) == 0);
      tmp.tgt       = {$urandom, $urandom};
      tmp.mdu_start = ($urandom_range(0, 9) == 0);
      tmp.mdu_done  = ($urandom_range(0, 4) == 0);
      tmp.halt      = halt_lvl;
      cyc(tmp, o1, o3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the 64-bit RV64 five-stage core.
- Decides each cycle whether the IF stage advances, holds or redirects:
  - drives `pc_stall`, `branch_taken` and `branch_target` into `if_stage`;
  - drives stall/flush controls for the IF/ID and ID/EX pipeline registers.
- Sequences the following by FSM: load-use interlocks of configurable length, multi-cycle MDU (mul/div) occupancy, branch redirects and debug halt.

Parameters:
- `XLEN`, 64, width of PC and branch target.
- `LOAD_STALL_CYCLES`, 1, bubble cycles inserted per load-use hazard (1..7).
- `CNT_W`, 32, width of performance counters (optional feature only).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`  in  5  source reg 1 of instruction in ID.
- `id_rs2`  in  5  source reg 2 of instruction in ID.
- `id_uses_rs1`  in  1  ID instruction reads rs1.
- `id_uses_rs2`  in  1  ID instruction reads rs2.
- `ex_rd`  in  5  destination reg of instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_branch_taken`  in  1  EX resolved a taken branch/jump.
- `ex_branch_target`  in  XLEN  resolved target address.
- `ex_mdu_start`  in  1  EX issues a mul/div op (1-cycle pulse).
- `mdu_done`  in  1  MDU result ready (1-cycle pulse).
- `halt_req`  in  1  debug halt request, level.
- `pc_stall`  out  1  hold PC in `if_stage`.
- `branch_taken`  out  1  load `branch_target` into PC this edge.
- `branch_target`  out  XLEN  redirect address.
- `if_id_stall`  out  1  hold IF/ID register.
- `if_id_flush`  out  1  zero IF/ID (insert NOP 0x00000013).
- `id_ex_stall`  out  1  hold ID/EX register.
- `id_ex_flush`  out  1  insert bubble in ID/EX.
- `halted`  out  1  core is in HALT state.

Behaviour:
- FSM states: RUN, LD_STALL, MDU_WAIT, HALT. State is registered; outputs are combinational from state and inputs.
- Reset:
  - state = RUN, stall counter = 0;
  - every output = 0, `branch_target` = 0;
  - a reset asserted mid-stall or mid-MDU aborts immediately to RUN on the next edge.
- Load-use hazard (`hz`) is asserted when:
  - `ex_mem_read` = 1, and
  - `ex_rd` != 0, and
  - (`id_uses_rs1` and `id_rs1` == `ex_rd`) or (`id_uses_rs2` and `id_rs2` == `ex_rd`).
- RUN, evaluated in priority order:
  1. `ex_branch_taken`:
     - outputs: `branch_taken` = 1, `branch_target` = `ex_branch_target`, `if_id_flush` = 1, `id_ex_flush` = 1, `pc_stall` = 0;
     - state stays RUN;
     - `hz`, `ex_mdu_start` and `halt_req` are ignored this cycle.
  2. `ex_mdu_start`:
     - outputs: `pc_stall` = 1, `if_id_stall` = 1, `id_ex_stall` = 1;
     - next state MDU_WAIT.
  3. `hz`:
     - outputs: `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1;
     - if `LOAD_STALL_CYCLES` > 1: counter = `LOAD_STALL_CYCLES` - 1, next state LD_STALL; otherwise remain RUN.
  4. `halt_req`: `pc_stall` = 1, `if_id_stall` = 1, next state HALT.
  5. Otherwise: all outputs 0.
- LD_STALL:
  - outputs: `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1;
  - counter decrements each cycle; when counter == 1, next state RUN;
  - total bubbles inserted = `LOAD_STALL_CYCLES` exactly.
- MDU_WAIT:
  - outputs: `pc_stall` = 1, `if_id_stall` = 1, `id_ex_stall` = 1;
  - on `mdu_done`: outputs stay asserted that cycle, next state RUN;
  - `ex_branch_taken` and `halt_req` are ignored while waiting.
- HALT:
  - outputs: `pc_stall` = 1, `if_id_stall` = 1, `halted` = 1;
  - when `halt_req` = 0, next state RUN, with `halted` deasserting the same cycle.
- `branch_taken` is 0 in every state except RUN case 1.
- `branch_target` is driven 0 whenever `branch_taken` = 0.
- Never assert a stall and a flush on the same pipeline register in one cycle; flush loses to stall on IF/ID.

Optional Feature:
- Macro: `PIPE_HAZARD_CTRL_PERF_EN`.
- When defined, three `CNT_W`-bit output ports are added:
  - `perf_stall_cycles`: increments every cycle `pc_stall` = 1;
  - `perf_flush_count`: increments per `branch_taken` pulse;
  - `perf_mdu_cycles`: increments every cycle in MDU_WAIT.
- All counters reset to 0 on `rst` and saturate at all-ones.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load-use, `LOAD_STALL_CYCLES`=1: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 for one cycle -> exactly 1 cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1, then all 0; PC held at 0x8 for that cycle.
- Load-use with `LOAD_STALL_CYCLES`=3 and a second case with `ex_rd`=0 -> the `ex_rd`=5 case gives 3 consecutive stall cycles, then RUN; the `ex_rd`=0 case gives no stall.
- Branch coincident with hazard: `ex_branch_taken`=1, target 0x28, `hz`=1 -> `branch_taken`=1, `branch_target`=0x28, `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0; the next fetched PC is 0x28.
- MDU: `ex_mdu_start` pulse, `mdu_done` pulses 6 cycles later -> `pc_stall`=`id_ex_stall`=1 for 7 cycles, release on the cycle after `done`; a branch asserted during the wait is ignored.
- Halt: `halt_req`=1 for 4 cycles during RUN -> `halted`=1 with `pc_stall`=1 held; on deassert PC resumes incrementing from the held value.
- Reset mid-MDU_WAIT: assert `rst` 1 cycle -> all outputs 0 the next cycle, state RUN; a later `mdu_done` has no effect.
